// File: rtl/mem_access_if.sv
// mem_access_if: Execute-side request, writeback and byte-RAM signals of the MEM stage.
interface mem_access_if #(
  parameter int ADDR_LEN     = 32,
  parameter int REG_LEN      = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic                    load_enable_i;
  logic                    store_enable_i;
  logic [ADDR_LEN-1:0]     load_store_addr_i;
  logic [REG_LEN-1:0]      data_i;
  logic [2:0]              funct3_i;
  logic [REG_ADDR_LEN-1:0] rd_addr_i;
  logic                    rd_write_enable_i;
  logic [7:0]              mem_din_i;
  logic [7:0]              mem_dout_o;
  logic [ADDR_LEN-1:0]     mem_a_o;
  logic                    mem_wr_o;
  logic [REG_LEN-1:0]      rd_data_o;
  logic [REG_ADDR_LEN-1:0] rd_addr_o;
  logic                    rd_write_enable_o;
  logic                    stall_o;
  modport master (
    output load_enable_i, store_enable_i, load_store_addr_i, data_i, funct3_i,
           rd_addr_i, rd_write_enable_i, mem_din_i,
    input  mem_dout_o, mem_a_o, mem_wr_o, rd_data_o, rd_addr_o, rd_write_enable_o, stall_o
  );
  modport slave (
    input  load_enable_i, store_enable_i, load_store_addr_i, data_i, funct3_i,
           rd_addr_i, rd_write_enable_i, mem_din_i,
    output mem_dout_o, mem_a_o, mem_wr_o, rd_data_o, rd_addr_o, rd_write_enable_o, stall_o
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage, byte-serial little-endian loads/stores on an 8-bit RAM with pipeline stall.
module mem_access #(
  parameter int ADDR_LEN     = 32,
  parameter int REG_LEN      = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input logic        clk_in,
  input logic        rst_in,
  mem_access_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2, DONE = 2'd3;
  logic [1:0]              state_q, state_d, bi;
  logic [2:0]              cnt_q, cnt_d, f3_q, f3_d, n_bytes;
  logic [ADDR_LEN-1:0]     addr_q, addr_d;
  logic [REG_LEN-1:0]      data_q, data_d, buf_q, buf_d, ext, rd_data_q, rd_data_d;
  logic [REG_ADDR_LEN-1:0] rd_q, rd_d, rd_addr_q, rd_addr_d;
  logic                    we_q, we_d, rd_we_q, rd_we_d, req, access;
  assign req       = bus.load_enable_i | bus.store_enable_i;
  assign n_bytes   = f3_q[1:0] == 2'b00 ? 3'd1 : f3_q[1:0] == 2'b01 ? 3'd2 : 3'd4;
  assign access    = state_q == STORE || (state_q == LOAD && cnt_q < n_bytes);
  assign bi        = 2'(cnt_q - 3'd1);
  assign bus.mem_a_o    = access ? addr_q + ADDR_LEN'(cnt_q) : '0;
  assign bus.mem_wr_o   = state_q == STORE;
  assign bus.mem_dout_o = state_q == STORE ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.stall_o    = !rst_in && (state_q == LOAD || state_q == STORE || (state_q == IDLE && req));
  assign bus.rd_data_o         = rd_data_q;
  assign bus.rd_addr_o         = rd_addr_q;
  assign bus.rd_write_enable_o = rd_we_q;
  // RAM returns the byte one cycle after its address, so cycle cnt holds byte cnt-1
  always_comb begin
    buf_d = buf_q;
    if (state_q == LOAD && cnt_q != 3'd0) buf_d[{bi, 3'b000} +: 8] = bus.mem_din_i;
  end
  assign ext = n_bytes == 3'd1 ? {{(REG_LEN-8){~f3_q[2] & buf_d[7]}}, buf_d[7:0]}
             : n_bytes == 3'd2 ? {{(REG_LEN-16){~f3_q[2] & buf_d[15]}}, buf_d[15:0]} : buf_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    data_d    = data_q;
    rd_d      = rd_q;
    we_d      = we_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    rd_we_d   = rd_we_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.load_enable_i) begin
          state_d = LOAD;
          addr_d  = bus.load_store_addr_i;
          f3_d    = bus.funct3_i;
          rd_d    = bus.rd_addr_i;
          we_d    = bus.rd_write_enable_i;
          rd_we_d = 1'b0;
        end else if (bus.store_enable_i) begin
          state_d = STORE;
          addr_d  = bus.load_store_addr_i;
          f3_d    = bus.funct3_i;
          data_d  = bus.data_i;
          rd_we_d = 1'b0;
        end else begin
          rd_data_d = bus.data_i;
          rd_addr_d = bus.rd_addr_i;
          rd_we_d   = bus.rd_write_enable_i;
        end
      end
      LOAD: begin
        rd_we_d = 1'b0;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == n_bytes) begin
          state_d   = DONE;
          cnt_d     = '0;
          rd_data_d = ext;
          rd_addr_d = rd_q;
          rd_we_d   = we_q;
        end
      end
      STORE: begin
        rd_we_d = 1'b0;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == n_bytes - 3'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      data_q    <= '0;
      buf_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      data_q    <= data_d;
      buf_q     <= buf_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
      rd_we_q   <= rd_we_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: bench for mem_access with a byte RAM model and queue scoreboards for writebacks and RAM writes.
module tb_mem_access;
  typedef struct {logic [31:0] d; logic [4:0] a; logic we;} wb_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_tests = 0, n_fail = 0;
  logic [7:0] ram [logic [31:0]];
  wb_t exp_rd[$];
  wr_t exp_wr[$], wr_seen[$];
  logic obs_stall, obs_wr, obs_rdwe;
  logic [31:0] obs_a, obs_rdd;
  logic [7:0] obs_dout;
  logic [4:0] obs_rda;
  logic stall_log [24];
  logic wr_log [24];
  logic [31:0] a_log [24];

  mem_access_if bus();
  mem_access dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step;
    logic [7:0] nxt;
    @(negedge clk);
    obs_stall = bus.stall_o;
    obs_a     = bus.mem_a_o;
    obs_wr    = bus.mem_wr_o;
    obs_dout  = bus.mem_dout_o;
    obs_rdd   = bus.rd_data_o;
    obs_rda   = bus.rd_addr_o;
    obs_rdwe  = bus.rd_write_enable_o;
    if (obs_wr === 1'b1) begin
      ram[obs_a] = obs_dout;
      wr_seen.push_back('{a: obs_a, d: obs_dout});
    end
    nxt = ram.exists(obs_a) ? ram[obs_a] : 8'h00;
    @(posedge clk);
    #1;
    bus.mem_din_i = nxt;
  endtask

  task automatic run_op(input logic ld, input logic st, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input logic [4:0] rd, input logic we, input int hold,
                        output int done_c);
    bus.load_enable_i = ld;
    bus.store_enable_i = st;
    bus.load_store_addr_i = a;
    bus.funct3_i = f3;
    bus.data_i = d;
    bus.rd_addr_i = rd;
    bus.rd_write_enable_i = we;
    wr_seen.delete();
    done_c = -1;
    for (int c = 0; c < 24; c++) begin
      stall_log[c] = 1'b0;
      wr_log[c] = 1'b0;
      a_log[c] = '0;
    end
    for (int c = 0; c < 24; c++) begin
      if (c == hold) begin
        bus.load_enable_i = 1'b0;
        bus.store_enable_i = 1'b0;
      end
      step();
      stall_log[c] = obs_stall;
      a_log[c] = obs_a;
      wr_log[c] = obs_wr;
      if (obs_stall !== 1'b1 && c > 0) begin
        done_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.load_enable_i = 1'b1;
    step();
    step();
    n_tests++;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", obs_stall); end
    n_tests++;
    if (bus.rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data_o); end
    n_tests++;
    if (bus.rd_addr_o !== 5'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h expected 0", bus.rd_addr_o); end
    n_tests++;
    if (bus.rd_write_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we: got %b expected 0", bus.rd_write_enable_o); end
    n_tests++;
    if ({bus.mem_wr_o, bus.mem_a_o, bus.mem_dout_o} !== 41'h0) begin
      n_fail++; $display("FAIL reset_mem: got wr=%b a=%h dout=%h expected all 0", bus.mem_wr_o, bus.mem_a_o, bus.mem_dout_o);
    end
    bus.load_enable_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_alu;
    wb_t e;
    bus.data_i = 32'h1234;
    bus.rd_addr_i = 5'd5;
    bus.rd_write_enable_i = 1'b1;
    exp_rd.push_back('{d: 32'h1234, a: 5'd5, we: 1'b1});
    step();
    n_tests++;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", obs_stall); end
    e = exp_rd.pop_front();
    n_tests++;
    if (bus.rd_data_o !== e.d || bus.rd_addr_o !== e.a || bus.rd_write_enable_o !== e.we) begin
      n_fail++; $display("FAIL alu_pass: got %h/%0d/%b expected %h/%0d/%b",
                         bus.rd_data_o, bus.rd_addr_o, bus.rd_write_enable_o, e.d, e.a, e.we);
    end
  endtask

  task automatic test_lw;
    int dc;
    wb_t e;
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    exp_rd.push_back('{d: 32'h12345678, a: 5'd7, we: 1'b1});
    run_op(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, 5'd7, 1'b1, 1, dc);
    n_tests++;
    if (dc !== 6) begin n_fail++; $display("FAIL lw_latency: got done cycle %0d expected 6", dc); end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (stall_log[c] !== 1'b1) begin n_fail++; $display("FAIL lw_stall[%0d]: got %b expected 1", c, stall_log[c]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (a_log[i+1] !== 32'h100 + i || wr_log[i+1] !== 1'b0) begin
        n_fail++; $display("FAIL lw_addr[%0d]: got %h wr=%b expected %h wr=0", i, a_log[i+1], wr_log[i+1], 32'h100 + i);
      end
    end
    n_tests++;
    if (a_log[5] !== 32'h0) begin n_fail++; $display("FAIL lw_idle_addr: got %h expected 0", a_log[5]); end
    e = exp_rd.pop_front();
    n_tests++;
    if (obs_rdd !== e.d || obs_rda !== e.a || obs_rdwe !== e.we) begin
      n_fail++; $display("FAIL lw_result: got %h/%0d/%b expected %h/%0d/%b", obs_rdd, obs_rda, obs_rdwe, e.d, e.a, e.we);
    end
  endtask

  task automatic test_byte_half;
    logic [2:0] f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h200, 32'h200, 32'h201, 32'h201};
    int lat [4] = '{3, 3, 4, 4};
    int dc;
    wb_t e;
    ram[32'h200] = 8'h80; ram[32'h201] = 8'h01; ram[32'h202] = 8'hFF;
    exp_rd.push_back('{d: 32'hFFFFFF80, a: 5'd3, we: 1'b1});
    exp_rd.push_back('{d: 32'h00000080, a: 5'd3, we: 1'b1});
    exp_rd.push_back('{d: 32'hFFFFFF01, a: 5'd3, we: 1'b1});
    exp_rd.push_back('{d: 32'h0000FF01, a: 5'd3, we: 1'b1});
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b0, ad[i], f3[i], 32'h0, 5'd3, 1'b1, 1, dc);
      n_tests++;
      if (dc !== lat[i]) begin n_fail++; $display("FAIL bh_latency[%0d]: got %0d expected %0d", i, dc, lat[i]); end
      e = exp_rd.pop_front();
      n_tests++;
      if (obs_rdd !== e.d || obs_rdwe !== e.we) begin
        n_fail++; $display("FAIL bh_result[%0d]: got %h we=%b expected %h we=%b", i, obs_rdd, obs_rdwe, e.d, e.we);
      end
    end
  endtask

  task automatic test_store;
    int dc;
    wr_t e, o;
    exp_wr.push_back('{a: 32'hFFFFFFFE, d: 8'hDD});
    exp_wr.push_back('{a: 32'hFFFFFFFF, d: 8'hCC});
    exp_wr.push_back('{a: 32'h00000000, d: 8'hBB});
    exp_wr.push_back('{a: 32'h00000001, d: 8'hAA});
    run_op(1'b0, 1'b1, 32'hFFFFFFFE, 3'b010, 32'hAABBCCDD, 5'd9, 1'b1, 1, dc);
    n_tests++;
    if (dc !== 5) begin n_fail++; $display("FAIL sw_latency: got done cycle %0d expected 5", dc); end
    n_tests++;
    if (wr_log[4] !== 1'b1) begin n_fail++; $display("FAIL sw_last_write: got wr=%b at cycle 4 expected 1", wr_log[4]); end
    n_tests++;
    if (wr_seen.size() != 4) begin n_fail++; $display("FAIL sw_count: got %0d writes expected 4", wr_seen.size()); end
    while (exp_wr.size() > 0 && wr_seen.size() > 0) begin
      e = exp_wr.pop_front();
      o = wr_seen.pop_front();
      n_tests++;
      if (o.a !== e.a || o.d !== e.d) begin n_fail++; $display("FAIL sw_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
    end
    exp_wr.delete();
    n_tests++;
    if (obs_rdwe !== 1'b0) begin n_fail++; $display("FAIL sw_rd_we: got %b expected 0", obs_rdwe); end
    exp_wr.push_back('{a: 32'h300, d: 8'hEE});
    run_op(1'b0, 1'b1, 32'h300, 3'b000, 32'h123456EE, 5'd9, 1'b1, 1, dc);
    n_tests++;
    if (dc !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", dc); end
    e = exp_wr.pop_front();
    n_tests++;
    if (wr_seen.size() != 1 || wr_seen[0].a !== e.a || wr_seen[0].d !== e.d) begin
      n_fail++; $display("FAIL sb_write: got %0d writes first %h expected one %h@%h",
                         wr_seen.size(), wr_seen.size() > 0 ? wr_seen[0].d : 8'h00, e.d, e.a);
    end
  endtask

  task automatic test_both;
    int dc, nw;
    wb_t e;
    exp_rd.push_back('{d: 32'h12345678, a: 5'd4, we: 1'b1});
    run_op(1'b1, 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 5'd4, 1'b1, 1, dc);
    nw = 0;
    for (int c = 0; c < 24; c++) if (wr_log[c] === 1'b1) nw++;
    n_tests++;
    if (nw != 0) begin n_fail++; $display("FAIL both_no_write: got %0d write cycles expected 0", nw); end
    e = exp_rd.pop_front();
    n_tests++;
    if (obs_rdd !== e.d || dc !== 6) begin n_fail++; $display("FAIL both_load: got %h at %0d expected %h at 6", obs_rdd, dc, e.d); end
  endtask

  task automatic test_back_to_back;
    int dc, nr;
    run_op(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, 5'd6, 1'b1, 100, dc);
    nr = 0;
    for (int c = 0; c < 24; c++) if (stall_log[c] === 1'b1 && wr_log[c] === 1'b0 && a_log[c] != 32'h0) nr++;
    n_tests++;
    if (dc !== 6 || nr != 4) begin n_fail++; $display("FAIL b2b_reads: got %0d reads done %0d expected 4 reads done 6", nr, dc); end
    n_tests++;
    if (obs_rdd !== 32'h12345678) begin n_fail++; $display("FAIL b2b_result: got %h expected 12345678", obs_rdd); end
    bus.load_enable_i = 1'b0;
    step();
    n_tests++;
    if (obs_stall !== 1'b0 || obs_a !== 32'h0) begin
      n_fail++; $display("FAIL b2b_no_reaccept: got stall=%b a=%h expected stall=0 a=0", obs_stall, obs_a);
    end
  endtask

  task automatic test_reset_mid;
    bus.store_enable_i = 1'b1;
    bus.load_store_addr_i = 32'h400;
    bus.funct3_i = 3'b010;
    bus.data_i = 32'h11223344;
    step();
    n_tests++;
    if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got stall %b expected 1", obs_stall); end
    bus.store_enable_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall_in_reset: got %b expected 0", obs_stall); end
    rst = 1'b0;
    step();
    n_tests++;
    if (obs_wr !== 1'b0 || obs_stall !== 1'b0 || obs_a !== 32'h0) begin
      n_fail++; $display("FAIL rmid_abort: got wr=%b stall=%b a=%h expected 0/0/0", obs_wr, obs_stall, obs_a);
    end
    n_tests++;
    if (obs_rdd !== 32'h0 || obs_rda !== 5'h0 || obs_rdwe !== 1'b0) begin
      n_fail++; $display("FAIL rmid_rd: got %h/%0d/%b expected 0/0/0", obs_rdd, obs_rda, obs_rdwe);
    end
    n_tests++;
    if (ram[32'h400] !== 8'h44) begin n_fail++; $display("FAIL rmid_kept_byte: got %h expected 44", ram[32'h400]); end
  endtask

  initial begin
    bus.load_enable_i = 1'b0;
    bus.store_enable_i = 1'b0;
    bus.load_store_addr_i = '0;
    bus.data_i = '0;
    bus.funct3_i = '0;
    bus.rd_addr_i = '0;
    bus.rd_write_enable_i = 1'b0;
    bus.mem_din_i = '0;
    test_reset();
    test_alu();
    test_lw();
    test_byte_half();
    test_store();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
